distance_display: RTL and testbench

Seven-segment display stage downstream of the slicing machine top level. It consumes the ultrasonic distance result (`distance_o` with the sensor's valid strobe) and the slice-count setting (`slice_num_o`). It converts both to decimal with an iterative double-dabble engine and drives eight active-low seven-segment digits for the operator panel. A hold-off timer keeps the distance readout legible, and a one-deep pending buffer guarantees the newest sample is eventually shown.

---
 rtl/distance_display.sv | 197 +++++++++++++++++++
 tb/tb_distance_display.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/distance_display.sv
// rtl/distance_display.sv - Distance and slice-count seven-segment display stage
//
// Converts the binary distance sample to BCD with an iterative double-dabble
// engine (one iteration per clock) and drives eight active-low digits.
// A hold-off timer keeps each distance readout on screen for HOLD_CYCLES
// cycles. A one-entry pending buffer keeps the newest sample that arrives
// while the engine is busy.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   valid_i        one-cycle strobe, distance_i valid
//   distance_i     unsigned distance, DIST_W bits
//   slice_num_i    slice count 0..31
//   hex0_o..hex5_o distance digits (units on hex0), active-low gfedcba
//   hex6_o/hex7_o  slice count units / tens
//   busy_o         high in any state other than IDLE
//   bcd_o          currently displayed distance in BCD
module distance_display #(
  parameter int DIST_W      = 17,
  parameter int HOLD_CYCLES = 5000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DIST_W-1:0] distance_i,
  input  logic [4:0]        slice_num_i,
  output logic [6:0]        hex0_o,
  output logic [6:0]        hex1_o,
  output logic [6:0]        hex2_o,
  output logic [6:0]        hex3_o,
  output logic [6:0]        hex4_o,
  output logic [6:0]        hex5_o,
  output logic [6:0]        hex6_o,
  output logic [6:0]        hex7_o,
  output logic              busy_o,
  output logic [23:0]       bcd_o
);

  localparam int CNT_W = (DIST_W > 1) ? $clog2(DIST_W) : 1;
  localparam int HLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIST_W - 1);
  localparam logic [HLD_W-1:0] HOLD_INIT = HLD_W'(HOLD_CYCLES);
  localparam logic [6:0]       SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state_q;
  logic [DIST_W-1:0] bin_q;
  logic [23:0]       bcd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [HLD_W-1:0]  hold_q;
  logic [23:0]       disp_q;
  logic              pend_q;
  logic [DIST_W-1:0] pend_data_q;
  logic [6:0]        hex6_q;
  logic [6:0]        hex7_q;

  logic [23:0]       bcd_add3_d;
  logic [1:0]        slice_tens_d;
  logic [4:0]        slice_units_d;
  logic [6:0]        dig_d [6];
  logic              lead_d;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Add-3 correction on every nibble before the shift.
  always_comb begin
    bcd_add3_d = bcd_q;
    for (int i = 0; i < 6; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_add3_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      hold_q      <= '0;
      disp_q      <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
    end else begin
      // Any strobe that cannot be started now replaces the pending sample.
      if (valid_i && state_q != IDLE) begin
        pend_q      <= 1'b1;
        pend_data_q <= distance_i;
      end
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            bin_q   <= distance_i;
            bcd_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            state_q <= SHIFT;
          end else if (pend_q) begin
            bin_q   <= pend_data_q;
            bcd_q   <= '0;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          bcd_q <= {bcd_add3_d[22:0], bin_q[DIST_W-1]};
          bin_q <= bin_q << 1;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= UPDATE;
          end
        end
        UPDATE: begin
          disp_q  <= bcd_q;
          hold_q  <= HOLD_INIT;
          state_q <= (HOLD_CYCLES == 0) ? IDLE : HOLD;
        end
        HOLD: begin
          hold_q <= hold_q - HLD_W'(1);
          if (hold_q == HLD_W'(1)) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Slice count split into tens/units without a divider (range is 0..31).
  always_comb begin
    if (slice_num_i >= 5'd30) begin
      slice_tens_d = 2'd3;
    end else if (slice_num_i >= 5'd20) begin
      slice_tens_d = 2'd2;
    end else if (slice_num_i >= 5'd10) begin
      slice_tens_d = 2'd1;
    end else begin
      slice_tens_d = 2'd0;
    end
    slice_units_d = slice_num_i - 5'(slice_tens_d * 4'd10);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex6_q <= seg7(4'd0);
      hex7_q <= SEG_BLANK;
    end else begin
      hex6_q <= seg7(slice_units_d[3:0]);
      hex7_q <= (slice_tens_d == 2'd0) ? SEG_BLANK : seg7({2'b00, slice_tens_d});
    end
  end

  // Leading-zero blanking: scan from the top digit down; once a nonzero
  // digit is seen every lower digit is lit. The units digit is always lit.
  always_comb begin
    lead_d = 1'b0;
    for (int i = 5; i >= 0; i--) begin
      lead_d   = lead_d | (disp_q[4*i +: 4] != 4'd0) | (i == 0);
      dig_d[i] = lead_d ? seg7(disp_q[4*i +: 4]) : SEG_BLANK;
    end
  end

  assign hex0_o = dig_d[0];
  assign hex1_o = dig_d[1];
  assign hex2_o = dig_d[2];
  assign hex3_o = dig_d[3];
  assign hex4_o = dig_d[4];
  assign hex5_o = dig_d[5];
  assign hex6_o = hex6_q;
  assign hex7_o = hex7_q;
  assign busy_o = (state_q != IDLE);
  assign bcd_o  = disp_q;

endmodule

// File: tb/tb_distance_display.sv
// tb/tb_distance_display.sv - Scoreboard testbench for distance_display
module tb_distance_display;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [16:0] distance_i;
  logic [4:0]  slice_num_i;
  logic [6:0]  hex0_o, hex1_o, hex2_o, hex3_o, hex4_o, hex5_o, hex6_o, hex7_o;
  logic        busy_o;
  logic [23:0] bcd_o;

  distance_display #(.DIST_W(17), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .distance_i(distance_i),
    .slice_num_i(slice_num_i),
    .hex0_o(hex0_o), .hex1_o(hex1_o), .hex2_o(hex2_o), .hex3_o(hex3_o),
    .hex4_o(hex4_o), .hex5_o(hex5_o), .hex6_o(hex6_o), .hex7_o(hex7_o),
    .busy_o(busy_o), .bcd_o(bcd_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind 0: display (bcd + hex5..hex0), kind 1: busy, kind 2: {hex7,hex6}
  typedef struct {
    int          cyc;
    int          kind;
    logic [23:0] bcd;
    logic [41:0] hex;
  } exp_t;

  exp_t        sbq[$];
  int          npass = 0;
  int          ntotal = 0;
  logic [23:0] prev_bcd = 24'h0;

  function automatic void push(int c, int kind, logic [23:0] b, logic [41:0] h);
    exp_t e;
    e.cyc = c; e.kind = kind; e.bcd = b; e.hex = h;
    sbq.push_back(e);
  endfunction

  always @(negedge clk) begin
    bit          disp_seen;
    logic [41:0] hx;
    disp_seen = 1'b0;
    hx = {hex5_o, hex4_o, hex3_o, hex2_o, hex1_o, hex0_o};
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].cyc == cyc) begin
        ntotal++;
        case (sbq[i].kind)
          0: begin
            disp_seen = 1'b1;
            if (bcd_o === sbq[i].bcd && hx === sbq[i].hex) npass++;
            else $display("FAIL display cyc=%0d got bcd=%h hex=%b exp bcd=%h hex=%b",
                          cyc, bcd_o, hx, sbq[i].bcd, sbq[i].hex);
          end
          1: begin
            if (busy_o === sbq[i].hex[0]) npass++;
            else $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy_o, sbq[i].hex[0]);
          end
          default: begin
            if ({hex7_o, hex6_o} === sbq[i].hex[13:0]) npass++;
            else $display("FAIL slice cyc=%0d got=%b exp=%b", cyc, {hex7_o, hex6_o},
                          sbq[i].hex[13:0]);
          end
        endcase
        sbq.delete(i);
      end
    end
    if (!disp_seen && bcd_o !== prev_bcd) begin
      ntotal++;
      $display("FAIL unexpected_update cyc=%0d got=%h exp=%h", cyc, bcd_o, prev_bcd);
    end
    prev_bcd = bcd_o;
  end

  task automatic wait_cyc(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Strobe valid_i so it is sampled at the next edge; k returns that edge index.
  task automatic strobe(logic [16:0] d, output int k);
    valid_i = 1'b1;
    distance_i = d;
    k = cyc + 1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
  endtask

  task automatic drive_slice(logic [4:0] v, logic [13:0] old_hex, logic [13:0] new_hex);
    slice_num_i = v;
    push(cyc, 2, 24'h0, {28'h0, old_hex});
    push(cyc + 1, 2, 24'h0, {28'h0, new_hex});
    wait_cyc(cyc + 3);
  endtask

  initial begin
    int k, kd;
    rst = 1'b1;
    valid_i = 1'b0;
    distance_i = '0;
    slice_num_i = 5'd0;
    push(2, 0, 24'h0, {SB, SB, SB, SB, SB, S0});
    push(2, 1, 24'h0, 42'd0);
    push(2, 2, 24'h0, {28'h0, SB, S0});
    wait_cyc(3);
    rst = 1'b0;

    // Full-scale value, latency and hold-off
    wait_cyc(5);
    strobe(17'd131071, k);
    push(k + 18, 0, 24'h131071, {S1, S3, S1, S0, S7, S1});
    push(k, 1, 24'h0, 42'd1);
    push(k + 21, 1, 24'h0, 42'd1);
    push(k + 22, 1, 24'h0, 42'd0);
    wait_cyc(k + 26);

    // Leading-zero blanking
    strobe(17'd205, k);
    push(k + 18, 0, 24'h000205, {SB, SB, SB, S2, S0, S5});
    wait_cyc(k + 26);
    strobe(17'd0, k);
    push(k + 18, 0, 24'h000000, {SB, SB, SB, SB, SB, S0});
    wait_cyc(k + 26);

    // Pending buffer keeps only the newest sample
    strobe(17'd100, k);
    push(k + 18, 0, 24'h000100, {SB, SB, SB, S1, S0, S0});
    push(k + 22, 1, 24'h0, 42'd0);
    push(k + 23, 1, 24'h0, 42'd1);
    push(k + 41, 0, 24'h000300, {SB, SB, SB, S3, S0, S0});
    wait_cyc(k + 4);
    strobe(17'd200, kd);
    wait_cyc(k + 9);
    strobe(17'd300, kd);
    wait_cyc(k + 70);

    // Slice digits
    drive_slice(5'd27, {SB, S0}, {S2, S7});
    drive_slice(5'd9,  {S2, S7}, {SB, S9});
    drive_slice(5'd31, {SB, S9}, {S3, S1});
    drive_slice(5'd10, {S3, S1}, {S1, S0});

    // Reset during SHIFT with a pending sample
    strobe(17'd500, k);
    wait_cyc(k + 2);
    strobe(17'd600, kd);
    wait_cyc(k + 8);
    push(k + 8, 0, 24'h000000, {SB, SB, SB, SB, SB, S0});
    push(k + 8, 1, 24'h0, 42'd0);
    push(k + 8, 2, 24'h0, {28'h0, SB, S0});
    rst = 1'b1;
    wait_cyc(k + 11);
    rst = 1'b0;
    push(k + 60, 0, 24'h000000, {SB, SB, SB, SB, SB, S0});
    push(k + 60, 1, 24'h0, 42'd0);
    wait_cyc(k + 64);

    foreach (sbq[i]) begin
      ntotal++;
      $display("FAIL never_checked cyc=%0d kind=%0d got=none exp=%h", sbq[i].cyc,
               sbq[i].kind, sbq[i].bcd);
    end
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
